// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative MUL/DIVU/DIV unit that
// freezes upstream via ExPauseRequest_o while it works.
module ex_stage #(
  parameter int          ITER_BITS         = 1,
  parameter logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcPlusOne_i,
  input  logic [31:0] regData1_i,
  input  logic [31:0] regData2_i,
  input  logic [31:0] immNumber_i,
  input  logic [3:0]  ALUoperation_i,
  input  logic [1:0]  ALUdata2Src_i,
  input  logic        ALUToReg_i,
  input  logic [2:0]  memOp_i,
  input  logic        MemToReg_i,
  input  logic        RegWrite_i,
  input  logic [4:0]  WriteRegDst_i,
  input  logic        stall_i,
  output logic [31:0] result_o,
  output logic [31:0] storeData_o,
  output logic        ALUToReg_o,
  output logic        MemToReg_o,
  output logic [2:0]  memOp_o,
  output logic        RegWrite_o,
  output logic [4:0]  WriteRegDst_o,
  output logic        ExPauseRequest_o
);

  localparam int         N          = 32 / ITER_BITS;
  localparam logic [5:0] COUNT_INIT = 6'(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] shf_q, shf_d;
  logic [31:0] opb_q, opb_d;
  logic        is_mul_q, is_mul_d;
  logic        neg_q, neg_d;
  logic [31:0] result_q, result_d;

  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_result;
  logic        is_muldiv;
  logic        pause;

  logic [31:0] it_acc, it_shf, it_opb;
  logic [32:0] it_rem;

  assign is_muldiv = (ALUoperation_i == 4'hD) || (ALUoperation_i == 4'hE) ||
                     (ALUoperation_i == 4'hF);

  always_comb begin
    case (ALUdata2Src_i)
      2'd1:    op_b = immNumber_i;
      2'd2:    op_b = pcPlusOne_i;
      default: op_b = regData2_i;
    endcase
    // Immediate shifts take the amount from the immediate, register shifts from A.
    shamt = (ALUdata2Src_i == 2'd1) ? immNumber_i[4:0] : regData1_i[4:0];
    alu_result = '0;
    case (ALUoperation_i)
      4'h0: alu_result = op_b;
      4'h1: alu_result = regData1_i + op_b;
      4'h2: alu_result = regData1_i - op_b;
      4'h3: alu_result = regData1_i & op_b;
      4'h4: alu_result = regData1_i | op_b;
      4'h5: alu_result = regData1_i ^ op_b;
      4'h6: alu_result = ~(regData1_i | op_b);
      4'h7: alu_result = regData2_i << shamt;
      4'h8: alu_result = regData2_i >> shamt;
      4'h9: alu_result = 32'($signed(regData2_i) >>> shamt);
      4'hA: alu_result = {31'b0, $signed(regData1_i) < $signed(op_b)};
      4'hB: alu_result = {31'b0, regData1_i < op_b};
      4'hC: alu_result = pcPlusOne_i;
      default: alu_result = '0;
    endcase
  end

  // MUL: acc=product, shf=multiplier, opb=multiplicand.
  // DIV: acc=partial remainder, shf=dividend shifting into quotient, opb=divisor.
  always_comb begin
    it_acc = acc_q;
    it_shf = shf_q;
    it_opb = opb_q;
    it_rem = '0;
    for (int i = 0; i < ITER_BITS; i++) begin
      if (is_mul_q) begin
        if (it_shf[0]) it_acc = it_acc + it_opb;
        it_opb = it_opb << 1;
        it_shf = it_shf >> 1;
      end else begin
        it_rem = {it_acc, it_shf[31]};
        it_shf = it_shf << 1;
        if (it_rem >= {1'b0, it_opb}) begin
          it_rem    = it_rem - {1'b0, it_opb};
          it_shf[0] = 1'b1;
        end
        it_acc = it_rem[31:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    shf_d    = shf_q;
    opb_d    = opb_q;
    is_mul_d = is_mul_q;
    neg_d    = neg_q;
    result_d = result_q;
    pause    = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_muldiv) begin
          pause    = 1'b1;
          is_mul_d = (ALUoperation_i == 4'hD);
          neg_d    = 1'b0;
          acc_d    = '0;
          count_d  = COUNT_INIT;
          if (ALUoperation_i == 4'hD) begin
            shf_d   = op_b;
            opb_d   = regData1_i;
            state_d = BUSY;
          end else if (op_b == '0) begin
            result_d = DIV_ZERO_QUOTIENT;
            state_d  = DONE;
          end else begin
            if (ALUoperation_i == 4'hF) begin
              shf_d = regData1_i[31] ? -regData1_i : regData1_i;
              opb_d = op_b[31] ? -op_b : op_b;
              neg_d = regData1_i[31] ^ op_b[31];
            end else begin
              shf_d = regData1_i;
              opb_d = op_b;
            end
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        pause   = 1'b1;
        acc_d   = it_acc;
        shf_d   = it_shf;
        opb_d   = it_opb;
        count_d = count_q - 6'd1;
        if (count_q == 6'd1) begin
          state_d  = DONE;
          result_d = is_mul_q ? it_acc : (neg_q ? -it_shf : it_shf);
        end
      end
      DONE: begin
        if (!stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      shf_q    <= '0;
      opb_q    <= '0;
      is_mul_q <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      shf_q    <= shf_d;
      opb_q    <= opb_d;
      is_mul_q <= is_mul_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // A paused stage hands EX/MEM a bubble; the destination still flows to decode.
  assign ExPauseRequest_o = pause;
  assign result_o         = (state_q == DONE) ? result_q : alu_result;
  assign storeData_o      = regData2_i;
  assign ALUToReg_o       = pause ? 1'b0 : ALUToReg_i;
  assign MemToReg_o       = pause ? 1'b0 : MemToReg_i;
  assign memOp_o          = pause ? 3'b0 : memOp_i;
  assign RegWrite_o       = pause ? 1'b0 : RegWrite_i;
  assign WriteRegDst_o    = WriteRegDst_i;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: ALU ops, iterative mul/div latency,
// stall hold in DONE, back-to-back muldiv and mid-operation reset.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcPlusOne_i, regData1_i, regData2_i, immNumber_i;
  logic [3:0]  ALUoperation_i;
  logic [1:0]  ALUdata2Src_i;
  logic        ALUToReg_i, MemToReg_i, RegWrite_i, stall_i;
  logic [2:0]  memOp_i;
  logic [4:0]  WriteRegDst_i;
  logic [31:0] result_o, storeData_o;
  logic        ALUToReg_o, MemToReg_o, RegWrite_o, ExPauseRequest_o;
  logic [2:0]  memOp_o;
  logic [4:0]  WriteRegDst_o;

  int checks = 0;
  int errors = 0;

  ex_stage #(.ITER_BITS(1), .DIV_ZERO_QUOTIENT(32'hFFFFFFFF)) dut (
    .clk(clk), .rst(rst),
    .pcPlusOne_i(pcPlusOne_i), .regData1_i(regData1_i), .regData2_i(regData2_i),
    .immNumber_i(immNumber_i), .ALUoperation_i(ALUoperation_i),
    .ALUdata2Src_i(ALUdata2Src_i), .ALUToReg_i(ALUToReg_i), .memOp_i(memOp_i),
    .MemToReg_i(MemToReg_i), .RegWrite_i(RegWrite_i), .WriteRegDst_i(WriteRegDst_i),
    .stall_i(stall_i), .result_o(result_o), .storeData_o(storeData_o),
    .ALUToReg_o(ALUToReg_o), .MemToReg_o(MemToReg_o), .memOp_o(memOp_o),
    .RegWrite_o(RegWrite_o), .WriteRegDst_o(WriteRegDst_o),
    .ExPauseRequest_o(ExPauseRequest_o)
  );

  always #5 clk = ~clk;

  task automatic drive_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] r2, input logic [31:0] imm,
                          input logic [1:0] src);
    ALUoperation_i = op;
    regData1_i     = a;
    regData2_i     = r2;
    immNumber_i    = imm;
    ALUdata2Src_i  = src;
  endtask

  // Counts pause cycles up to the first non-paused cycle (bounded).
  task automatic wait_done(output int pauses, output bit leak, output bit timeout);
    pauses  = 0;
    leak    = 1'b0;
    timeout = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ExPauseRequest_o === 1'b1) begin
        pauses++;
        if (RegWrite_o !== 1'b0 || ALUToReg_o !== 1'b0 || MemToReg_o !== 1'b0 ||
            memOp_o !== 3'b0)
          leak = 1'b1;
      end else begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    stall_i = 1'b0;
    pcPlusOne_i = 32'h100;
    ALUToReg_i = 1'b1; MemToReg_i = 1'b0; RegWrite_i = 1'b1;
    memOp_i = 3'b101; WriteRegDst_i = 5'd9;
    drive_op(4'h0, 32'h0, 32'h1234, 32'h0, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ExPauseRequest_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_pause: got %b expected 0", ExPauseRequest_o);
    end
    checks++;
    if (result_o !== 32'h1234) begin
      errors++; $display("[TB] FAIL reset_result: got %h expected 00001234", result_o);
    end
    checks++;
    if (RegWrite_o !== 1'b1 || memOp_o !== 3'b101 || WriteRegDst_o !== 5'd9) begin
      errors++; $display("[TB] FAIL reset_passthru: got rw=%b mop=%b dst=%0d expected 1 101 9",
                         RegWrite_o, memOp_o, WriteRegDst_o);
    end
  endtask

  task automatic test_alu;
    logic [3:0]  ops  [11] = '{4'h1, 4'h9, 4'hA, 4'hB, 4'h2, 4'h6, 4'h7, 4'h8, 4'h0, 4'hC, 4'h5};
    logic [31:0] as   [11] = '{32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5,
                               32'h0F0F0F0F, 32'h23, 32'h1F, 32'h0, 32'h0, 32'hFFFF0000};
    logic [31:0] r2s  [11] = '{32'h0, 32'hF0000000, 32'h1, 32'h1, 32'h7, 32'h00FF00FF,
                               32'h1, 32'h80000000, 32'h0, 32'h9, 32'h0F0F0F0F};
    logic [31:0] imms [11] = '{32'h1, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                               32'h0, 32'h0, 32'h0};
    logic [1:0]  srcs [11] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] exps [11] = '{32'h80000000, 32'hFF000000, 32'h1, 32'h0, 32'hFFFFFFFE,
                               32'hF000F000, 32'h8, 32'h1, 32'h100, 32'h100, 32'hF0F00F0F};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      drive_op(ops[i], as[i], r2s[i], imms[i], srcs[i]);
      @(negedge clk);
      checks++;
      if (result_o !== exps[i] || ExPauseRequest_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL alu_vec%0d op=%h: got %h pause=%b expected %h pause=0",
                 i, ops[i], result_o, ExPauseRequest_o, exps[i]);
      end
    end
    checks++;
    if (storeData_o !== 32'h0F0F0F0F) begin
      errors++; $display("[TB] FAIL store_data: got %h expected 0f0f0f0f", storeData_o);
    end
    ALUToReg_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ALUToReg_o !== 1'b0) begin
      errors++; $display("[TB] FAIL alutoreg_follow: got %b expected 0", ALUToReg_o);
    end
    ALUToReg_i = 1'b1;
  endtask

  task automatic test_mul;
    int pauses; bit leak, timeout;
    @(posedge clk); #1;
    drive_op(4'hD, 32'h00012345, 32'h00010000, 32'h0, 2'd0);
    wait_done(pauses, leak, timeout);
    checks++;
    if (timeout || pauses != 33) begin
      errors++; $display("[TB] FAIL mul_latency: got %0d pauses timeout=%b expected 33", pauses, timeout);
    end
    checks++;
    if (leak) begin
      errors++; $display("[TB] FAIL mul_bubble: got control leak=1 expected 0");
    end
    checks++;
    if (result_o !== 32'h23450000 || RegWrite_o !== 1'b1) begin
      errors++; $display("[TB] FAIL mul_result: got %h rw=%b expected 23450000 rw=1", result_o, RegWrite_o);
    end
    @(posedge clk); #1;
    drive_op(4'h0, 32'h0, 32'h55, 32'h0, 2'd0);
    @(negedge clk);
    checks++;
    if (ExPauseRequest_o !== 1'b0 || result_o !== 32'h55) begin
      errors++; $display("[TB] FAIL mul_exit: got %h pause=%b expected 00000055 pause=0",
                         result_o, ExPauseRequest_o);
    end
  endtask

  task automatic test_div;
    int pauses; bit leak, timeout;
    @(posedge clk); #1;
    drive_op(4'hF, 32'hFFFFFFF9, 32'h2, 32'h0, 2'd0);
    wait_done(pauses, leak, timeout);
    checks++;
    if (timeout || pauses != 33 || result_o !== 32'hFFFFFFFD) begin
      errors++; $display("[TB] FAIL div_neg: got %h pauses=%0d expected fffffffd pauses=33", result_o, pauses);
    end
    @(posedge clk); #1;
    drive_op(4'hE, 32'h7, 32'h0, 32'h0, 2'd0);
    wait_done(pauses, leak, timeout);
    checks++;
    if (timeout || pauses != 1 || result_o !== 32'hFFFFFFFF) begin
      errors++; $display("[TB] FAIL divu_zero: got %h pauses=%0d expected ffffffff pauses=1", result_o, pauses);
    end
    @(posedge clk); #1;
    drive_op(4'hF, 32'h80000000, 32'hFFFFFFFF, 32'h0, 2'd0);
    wait_done(pauses, leak, timeout);
    checks++;
    if (timeout || pauses != 33 || result_o !== 32'h80000000) begin
      errors++; $display("[TB] FAIL div_min_neg1: got %h pauses=%0d expected 80000000 pauses=33", result_o, pauses);
    end
  endtask

  task automatic test_back_to_back;
    int pauses; bit leak, timeout;
    @(posedge clk); #1;
    drive_op(4'hE, 32'd100, 32'd3, 32'h0, 2'd0);
    wait_done(pauses, leak, timeout);
    checks++;
    if (timeout || pauses != 33 || result_o !== 32'd33) begin
      errors++; $display("[TB] FAIL b2b_first: got %0d pauses=%0d expected 33 pauses=33", result_o, pauses);
    end
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (result_o !== 32'd33 || ExPauseRequest_o !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_hold%0d: got %0d pause=%b expected 33 pause=0",
                           k, result_o, ExPauseRequest_o);
      end
    end
    stall_i = 1'b0;
    @(posedge clk); #1;
    drive_op(4'hE, 32'd9, 32'd3, 32'h0, 2'd0);
    wait_done(pauses, leak, timeout);
    checks++;
    if (timeout || pauses != 33 || result_o !== 32'd3) begin
      errors++; $display("[TB] FAIL b2b_second: got %0d pauses=%0d expected 3 pauses=33", result_o, pauses);
    end
  endtask

  task automatic test_reset_mid_op;
    int pauses; bit leak, timeout;
    @(posedge clk); #1;
    drive_op(4'hF, 32'd100, 32'hFFFFFFF9, 32'h0, 2'd0);
    repeat (5) @(negedge clk);
    checks++;
    if (ExPauseRequest_o !== 1'b1) begin
      errors++; $display("[TB] FAIL midop_busy: got pause=%b expected 1", ExPauseRequest_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive_op(4'h0, 32'h0, 32'h77, 32'h0, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ExPauseRequest_o !== 1'b0 || result_o !== 32'h77) begin
      errors++; $display("[TB] FAIL midop_abort: got %h pause=%b expected 00000077 pause=0",
                         result_o, ExPauseRequest_o);
    end
    @(posedge clk); #1;
    drive_op(4'hF, 32'd100, 32'hFFFFFFF9, 32'h0, 2'd0);
    wait_done(pauses, leak, timeout);
    checks++;
    if (timeout || pauses != 33 || result_o !== 32'hFFFFFFF2) begin
      errors++; $display("[TB] FAIL midop_reissue: got %h pauses=%0d expected fffffff2 pauses=33", result_o, pauses);
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_mul;
    test_div;
    test_back_to_back;
    test_reset_mid_op;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 32-bit five-stage pipeline. It sits between the ID/EX pipeline register and the EX/MEM pipeline register.
- Single-cycle ALU operations complete combinationally.
- MUL, DIVU and DIV run on an iterative shift/add/subtract unit. While it runs, the stage raises ExPauseRequest_o so the upstream stages freeze.
- It drives the ex_* bypass/hazard signals consumed by decode.

Parameters:
- ITER_BITS, 1, quotient/product bits resolved per clock. Legal values: 1, 2, 4. Iteration count N = 32/ITER_BITS.
- DIV_ZERO_QUOTIENT, 32'hFFFFFFFF, result for DIVU/DIV when divisor is 0.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
pcPlusOne_i  in  32  link value
regData1_i  in  32  operand A (already bypassed)
regData2_i  in  32  register operand / store data
immNumber_i  in  32  immediate
ALUoperation_i  in  4  operation code
ALUdata2Src_i  in  2  operand-B select: 0 regData2, 1 imm, 2 pcPlusOne, 3 regData2
ALUToReg_i  in  1  ALU result is written back
memOp_i  in  3  memory operation, passed through
MemToReg_i  in  1  load result is written back
RegWrite_i  in  1  writeback enable
WriteRegDst_i  in  5  destination register
stall_i  in  1  downstream (MEM) hold request
result_o  out  32  ALU result / memory address
storeData_o  out  32  = regData2_i
ALUToReg_o  out  1  bypass-valid to decode
MemToReg_o  out  1  to decode hazard check and EX/MEM
memOp_o  out  3  to EX/MEM
RegWrite_o  out  1  to EX/MEM
WriteRegDst_o  out  5  to decode and EX/MEM
ExPauseRequest_o  out  1  freeze PC, IF/ID and ID/EX

Behaviour:
- Reset: synchronous, active-high on clk. State=IDLE; iteration counter, remainder, quotient/product and result registers cleared. ExPauseRequest_o=0.
- Reset mid-operation aborts the operation; the stage is IDLE on the next cycle.

Operand and ALU rules:
- B = mux(ALUdata2Src_i).
- Ops: 0 pass B; 1 ADD A+B; 2 SUB A-B; 3 AND; 4 OR; 5 XOR; 6 NOR.
- Shifts: 7 SLL, 8 SRL, 9 SRA shift regData2_i. The amount is immNumber_i[4:0] when ALUdata2Src_i=1, otherwise regData1_i[4:0].
- Compares: A SLT signed, B SLTU. Result is 0 or 1.
- C: pcPlusOne_i.
- D MUL: low 32 bits of A*B.
- E DIVU: unsigned A/B.
- F DIV: signed A/B, truncating toward zero.
- Arithmetic wraps mod 2^32; there are no overflow traps.

Multi-cycle FSM (IDLE, BUSY, DONE):
- IDLE: an op in {D,E,F} asserts ExPauseRequest_o combinationally in the same cycle. Next state BUSY; counter loaded with N.
  - DIV: operand magnitudes are latched, and the result sign = sign(A) XOR sign(B).
  - B==0 skips BUSY: next state DONE, result = DIV_ZERO_QUOTIENT.
- BUSY: ExPauseRequest_o=1. Each clock does ITER_BITS steps and decrements the counter. At 1 the next state is DONE and the result register is written (sign fixed for DIV).
- DONE: ExPauseRequest_o=0 and result_o = result register.
  - stall_i=0: next state IDLE.
  - stall_i=1: stay DONE.
- Latency: N+1 cycles of pause, then one DONE cycle. Total N+2 cycles per muldiv instruction.
- Corner cases: 0x80000000 / 0xFFFFFFFF (DIV) = 0x80000000. Back-to-back muldiv instructions each take the full latency, because the DONE→IDLE cycle sees the new instruction.

Bubble and bypass rules:
- While ExPauseRequest_o=1, RegWrite_o, ALUToReg_o, MemToReg_o and memOp_o are forced to 0, so EX/MEM captures a bubble.
- Otherwise these outputs pass their inputs through. WriteRegDst_o always passes through.
- Single-cycle ops never assert pause. Inputs are assumed stable while paused, since upstream is frozen.

Test Plan:
- ADD with A=0x7FFFFFFF, imm=1, src=1 → result_o=0x80000000 same cycle, pause=0, ALUToReg_o follows input.
- SRA with regData2=0xF0000000, imm[4:0]=4, src=1 → 0xFF000000; SLT A=0xFFFFFFFF, B=1 → 1; SLTU same operands → 0.
- MUL A=0x00012345, B=0x00010000, ITER_BITS=1 → pause high exactly 33 cycles, then result 0x23450000 for one cycle, RegWrite_o=0 during pause.
- DIV A=-7 (0xFFFFFFF9), B=2 → 0xFFFFFFFD; DIVU A=7, B=0 → 0xFFFFFFFF after exactly 1 pause cycle.
- Two consecutive DIVU instructions (100/3 then 9/3) → results 33 then 3, each with full pause window; stall_i=1 held 3 cycles in DONE keeps result_o=33 stable.
- rst asserted mid-BUSY → next cycle pause=0, state IDLE; a re-issued DIV completes with the correct quotient.
